serial_word_tx: RTL and testbench

SERIAL_WORD_TX -- requirements
Module: serial_word_tx

---
 rtl/serial_word_tx_if.sv | 32 +++
 rtl/serial_word_tx.sv | 62 ++++++
 tb/tb_serial_word_tx.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_word_tx_if.sv
// rtl/serial_word_tx_if.sv - parallel word handshake and serial output bundle for serial_word_tx
interface serial_word_tx_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic [WIDTH-1:0] data_in;
   logic             ready;
   logic             conv_reset;
   logic             ser_out;
   logic             ser_valid;
   logic             done;

   modport slave (
      input  in_valid,
      input  data_in,
      output ready,
      output conv_reset,
      output ser_out,
      output ser_valid,
      output done
   );

   modport master (
      output in_valid,
      output data_in,
      input  ready,
      input  conv_reset,
      input  ser_out,
      input  ser_valid,
      input  done
   );
endinterface

// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - parallel word to LSB-first serial stream framed by converter clear and done
module serial_word_tx #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           reset,
   serial_word_tx_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] shift_reg;
   logic [CW-1:0]    bit_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.in_valid) next_state = CLEAR;
         CLEAR:   next_state = SHIFT;
         SHIFT:   if (bit_cnt == LAST) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else if (state == IDLE && bus.in_valid) begin
         shift_reg <= bus.data_in;
         bit_cnt   <= '0;
      end else if (state == SHIFT) begin
         shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
         bit_cnt   <= bit_cnt + 1'b1;
      end
   end

   // conv_reset also follows the raw reset so the downstream converter clears with us
   assign bus.conv_reset = reset | (state == CLEAR);
   assign bus.ready      = (state == IDLE);
   assign bus.ser_valid  = (state == SHIFT);
   assign bus.ser_out    = (state == SHIFT) & shift_reg[0];
   assign bus.done       = (state == DONE);
endmodule

// File: tb/tb_serial_word_tx.sv
// tb/tb_serial_word_tx.sv - directed self-checking bench for serial_word_tx
module tb_serial_word_tx;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   logic tr_cr [40];
   logic tr_sv [40];
   logic tr_so [40];
   logic tr_dn [40];
   logic tr_rdy[40];

   logic [7:0] conv_word;
   int         conv_idx;
   logic       conv_seen;

   always #5 clk = ~clk;

   serial_word_tx_if #(.WIDTH(8)) bus();
   serial_word_tx #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

   // Downstream serial two's-complement converter: copy through the first 1, invert after
   always @(posedge clk) begin
      if (bus.conv_reset) begin
         conv_word <= 8'h00;
         conv_idx  <= 0;
         conv_seen <= 1'b0;
      end else if (bus.ser_valid && conv_idx < 8) begin
         conv_word[conv_idx] <= conv_seen ? ~bus.ser_out : bus.ser_out;
         conv_seen <= conv_seen | bus.ser_out;
         conv_idx  <= conv_idx + 1;
      end
   end

   task automatic run_trace(input int n, input int nwords, input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2);
      logic [7:0] words[3];
      int   nxt;
      int   guard;
      logic prev_rdy;
      words[0] = w0; words[1] = w1; words[2] = w2;
      guard = 0;
      while (bus.ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (guard >= 50) begin
         failures++;
         $display("FAIL trace_wait ready=%b required 1", bus.ready);
      end
      bus.in_valid = 1'b1;
      bus.data_in  = w0;
      nxt = 1;
      prev_rdy = 1'b1;
      for (int c = 1; c <= n; c++) begin
         @(posedge clk);
         #1;
         if (prev_rdy) begin
            if (nxt < nwords) begin
               bus.data_in = words[nxt];
               nxt++;
            end else begin
               bus.in_valid = 1'b0;
               bus.data_in  = ~bus.data_in;
            end
         end
         @(negedge clk);
         tr_cr[c]  = bus.conv_reset;
         tr_sv[c]  = bus.ser_valid;
         tr_so[c]  = bus.ser_out;
         tr_dn[c]  = bus.done;
         tr_rdy[c] = bus.ready;
         prev_rdy  = bus.ready;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.data_in  = 8'h00;
      #1;
      checks++;
      if ({bus.ready, bus.conv_reset, bus.ser_out, bus.ser_valid, bus.done} !== 5'b11000) begin
         failures++;
         $display("FAIL reset_outputs got=%b required 11000",
                  {bus.ready, bus.conv_reset, bus.ser_out, bus.ser_valid, bus.done});
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (bus.conv_reset !== 1'b0 || bus.ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release conv_reset=%b ready=%b required 0 1", bus.conv_reset, bus.ready);
      end
   endtask

   task automatic test_basic();
      logic [7:0] exp;
      exp = 8'b00010100;
      run_trace(11, 1, exp, 8'h00, 8'h00);
      checks++;
      if (tr_cr[1] !== 1'b1 || tr_sv[1] !== 1'b0 || tr_so[1] !== 1'b0 || tr_rdy[1] !== 1'b0) begin
         failures++;
         $display("FAIL basic_clear cr=%b sv=%b so=%b rdy=%b required 1 0 0 0", tr_cr[1], tr_sv[1], tr_so[1], tr_rdy[1]);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (tr_sv[2+i] !== 1'b1 || tr_so[2+i] !== exp[i] || tr_cr[2+i] !== 1'b0) begin
            failures++;
            $display("FAIL basic_bit%0d sv=%b so=%b cr=%b required 1 %b 0", i, tr_sv[2+i], tr_so[2+i], tr_cr[2+i], exp[i]);
         end
      end
      checks++;
      if (tr_dn[10] !== 1'b1 || tr_sv[10] !== 1'b0 || tr_so[10] !== 1'b0 || tr_rdy[10] !== 1'b0) begin
         failures++;
         $display("FAIL basic_done dn=%b sv=%b so=%b rdy=%b required 1 0 0 0", tr_dn[10], tr_sv[10], tr_so[10], tr_rdy[10]);
      end
      checks++;
      if (tr_rdy[11] !== 1'b1 || tr_dn[11] !== 1'b0 || tr_sv[11] !== 1'b0) begin
         failures++;
         $display("FAIL basic_ready rdy=%b dn=%b sv=%b required 1 0 0", tr_rdy[11], tr_dn[11], tr_sv[11]);
      end
   endtask

   task automatic test_converter();
      run_trace(11, 1, 8'b00010100, 8'h00, 8'h00);
      checks++;
      if (conv_word !== 8'b11101100) begin
         failures++;
         $display("FAIL conv_minus20 got=%b required 11101100", conv_word);
      end
      run_trace(11, 1, 8'h01, 8'h00, 8'h00);
      checks++;
      if (conv_word !== 8'hFF) begin
         failures++;
         $display("FAIL conv_minus1 got=%h required ff", conv_word);
      end
   endtask

   task automatic test_busy();
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] got_a;
      logic [7:0] got_b;
      int         busy_clears;
      a = 8'hA5;
      b = 8'h3C;
      run_trace(22, 2, a, b, 8'h00);
      busy_clears = 0;
      for (int i = 0; i < 8; i++) begin
         got_a[i] = tr_so[2+i];
         got_b[i] = tr_so[13+i];
      end
      for (int c = 2; c <= 11; c++) busy_clears += int'(tr_cr[c]);
      checks++;
      if (got_a !== 8'hA5) begin
         failures++;
         $display("FAIL busy_word_a got=%h required a5", got_a);
      end
      checks++;
      if (busy_clears != 0 || tr_rdy[11] !== 1'b1 || tr_cr[12] !== 1'b1) begin
         failures++;
         $display("FAIL busy_accept clears=%0d rdy11=%b cr12=%b required 0 1 1", busy_clears, tr_rdy[11], tr_cr[12]);
      end
      checks++;
      if (got_b !== 8'h3C || tr_dn[21] !== 1'b1) begin
         failures++;
         $display("FAIL busy_word_b got=%h done21=%b required 3c 1", got_b, tr_dn[21]);
      end
   endtask

   task automatic test_mid_reset();
      logic [7:0] got;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.data_in  = 8'h5A;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (bus.ser_valid !== 1'b1) begin
         failures++;
         $display("FAIL midrst_in_shift ser_valid=%b required 1", bus.ser_valid);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.ready, bus.conv_reset, bus.ser_out, bus.ser_valid, bus.done} !== 5'b11000) begin
         failures++;
         $display("FAIL midrst_async got=%b required 11000",
                  {bus.ready, bus.conv_reset, bus.ser_out, bus.ser_valid, bus.done});
      end
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_hold done=%b ready=%b required 0 1", bus.done, bus.ready);
         end
      end
      reset = 1'b0;
      run_trace(11, 1, 8'hFF, 8'h00, 8'h00);
      for (int i = 0; i < 8; i++) got[i] = tr_so[2+i];
      checks++;
      if (tr_cr[1] !== 1'b1 || got !== 8'hFF || tr_dn[10] !== 1'b1) begin
         failures++;
         $display("FAIL midrst_after cr1=%b word=%h done10=%b required 1 ff 1", tr_cr[1], got, tr_dn[10]);
      end
      checks++;
      if (conv_word !== 8'h01) begin
         failures++;
         $display("FAIL midrst_conv got=%h required 01", conv_word);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] w[3];
      logic [7:0] got;
      int         n_cr;
      int         n_dn;
      w[0] = 8'h00; w[1] = 8'h80; w[2] = 8'hFF;
      run_trace(33, 3, w[0], w[1], w[2]);
      n_cr = 0;
      n_dn = 0;
      for (int c = 1; c <= 33; c++) begin
         n_cr += int'(tr_cr[c]);
         n_dn += int'(tr_dn[c]);
      end
      checks++;
      if (n_cr != 3 || n_dn != 3) begin
         failures++;
         $display("FAIL b2b_frames clears=%0d dones=%0d required 3 3", n_cr, n_dn);
      end
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 8; i++) got[i] = tr_so[2+11*k+i];
         checks++;
         if (tr_cr[1+11*k] !== 1'b1 || tr_dn[10+11*k] !== 1'b1 || got !== w[k] || tr_sv[9+11*k] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_word%0d cr=%b dn=%b word=%h required 1 1 %h", k, tr_cr[1+11*k], tr_dn[10+11*k], got, w[k]);
         end
      end
      checks++;
      if (tr_rdy[33] !== 1'b1) begin
         failures++;
         $display("FAIL b2b_final_ready got=%b required 1", tr_rdy[33]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_converter();
      test_busy();
      test_mid_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
